pulse_src_seq: RTL and testbench

- Clocked sequencer that generates a SPICE-style PULSE waveform as a stream of unsigned amplitude codes: delay, rise ramp, high, fall ramp, low, repeat.
- Sits directly upstream of the controlled-source models (VCVS/VCCS).
- Its level output is converted to the control voltage/current that drives the source's gain input.
- Replaces hand-written PWL stimulus in mixed-mode decks.

---
 rtl/pulse_src_seq.sv | 184 ++++++++++++++++++
 tb/tb_pulse_src_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_src_seq.sv
// SPICE-style PULSE sequencer: delay, rise ramp, high, fall ramp, low, repeat.
// Emits a registered stream of unsigned amplitude codes for controlled-source models.
module pulse_src_seq #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_v1,
    input  logic [WIDTH-1:0] cfg_v2,
    input  logic [CNT_W-1:0] cfg_td,
    input  logic [CNT_W-1:0] cfg_tw,
    input  logic [CNT_W-1:0] cfg_tl,
    input  logic [WIDTH-1:0] cfg_rstep,
    input  logic [WIDTH-1:0] cfg_fstep,
    input  logic [CNT_W-1:0] cfg_npulse,
    input  logic             enable,
    output logic [WIDTH-1:0] level,
    output logic             level_valid,
    output logic [2:0]       phase,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDelay = 3'd1,
        StRise  = 3'd2,
        StHigh  = 3'd3,
        StFall  = 3'd4,
        StLow   = 3'd5
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] level_q;
    logic             level_valid_q;
    logic             done_q;
    logic [CNT_W-1:0] pulse_cnt_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] v1_q, v2_q, rstep_q, fstep_q;
    logic [CNT_W-1:0] td_q, tw_q, tl_q, npulse_q;
    logic             cfg_loaded_q;

    logic             cfg_hs;
    logic [WIDTH-1:0] start_v1;
    logic [WIDTH-1:0] ramp_target;
    logic [WIDTH-1:0] ramp_step;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic             ramp_hit;
    logic [WIDTH-1:0] ramp_next;
    logic [CNT_W-1:0] pulse_inc;
    logic             last_pulse;

    assign cfg_hs    = cfg_valid && (state_q == StIdle);
    // A handshake coinciding with start must use the freshly presented values.
    assign start_v1  = cfg_hs ? cfg_v1 : v1_q;
    assign pulse_inc = pulse_cnt_q + CNT_W'(1);
    assign last_pulse = (npulse_q != '0) && (pulse_inc == npulse_q);

    always_comb begin
        ramp_target = (state_q == StFall) ? v1_q : v2_q;
        ramp_step   = (state_q == StFall) ? fstep_q : rstep_q;
        up_sum      = {1'b0, level_q} + {1'b0, ramp_step};
        dn_diff     = {1'b0, level_q} - {1'b0, ramp_step};
        ramp_hit    = 1'b0;
        if (ramp_step == '0 || level_q == ramp_target) begin
            ramp_hit = 1'b1;
        end else if (level_q < ramp_target) begin
            ramp_hit = (up_sum >= {1'b0, ramp_target});
        end else begin
            // MSB set means the subtraction wrapped below zero.
            ramp_hit = dn_diff[WIDTH] || (dn_diff <= {1'b0, ramp_target});
        end
        if (ramp_hit) begin
            ramp_next = ramp_target;
        end else if (level_q < ramp_target) begin
            ramp_next = up_sum[WIDTH-1:0];
        end else begin
            ramp_next = dn_diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            done_q        <= 1'b0;
            pulse_cnt_q   <= '0;
            cnt_q         <= '0;
            v1_q          <= '0;
            v2_q          <= '0;
            rstep_q       <= '0;
            fstep_q       <= '0;
            td_q          <= '0;
            tw_q          <= '0;
            tl_q          <= '0;
            npulse_q      <= '0;
            cfg_loaded_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cfg_hs) begin
                v1_q         <= cfg_v1;
                v2_q         <= cfg_v2;
                rstep_q      <= cfg_rstep;
                fstep_q      <= cfg_fstep;
                td_q         <= cfg_td;
                tw_q         <= cfg_tw;
                tl_q         <= cfg_tl;
                npulse_q     <= cfg_npulse;
                cfg_loaded_q <= 1'b1;
            end
            if (state_q != StIdle && !enable) begin
                state_q       <= StIdle;
                level_q       <= v1_q;
                level_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (enable && (cfg_loaded_q || cfg_hs)) begin
                            state_q       <= StDelay;
                            level_q       <= start_v1;
                            level_valid_q <= 1'b1;
                            pulse_cnt_q   <= '0;
                            cnt_q         <= CNT_W'(1);
                        end
                    end
                    StDelay: begin
                        if (cnt_q >= td_q) state_q <= StRise;
                        else cnt_q <= cnt_q + CNT_W'(1);
                    end
                    StRise: begin
                        level_q <= ramp_next;
                        if (ramp_hit) begin
                            if (tw_q == '0) begin
                                state_q <= StFall;
                            end else begin
                                state_q <= StHigh;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    StHigh: begin
                        if (cnt_q >= tw_q) state_q <= StFall;
                        else cnt_q <= cnt_q + CNT_W'(1);
                    end
                    StFall: begin
                        level_q <= ramp_next;
                        if (ramp_hit) begin
                            pulse_cnt_q <= pulse_inc;
                            if (last_pulse) begin
                                done_q        <= 1'b1;
                                state_q       <= StIdle;
                                level_valid_q <= 1'b0;
                            end else if (tl_q == '0) begin
                                state_q <= StRise;
                            end else begin
                                state_q <= StLow;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    StLow: begin
                        if (cnt_q >= tl_q) state_q <= StRise;
                        else cnt_q <= cnt_q + CNT_W'(1);
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign cfg_ready   = (state_q == StIdle);
    assign level       = level_q;
    assign level_valid = level_valid_q;
    assign phase       = state_q;
    assign done        = done_q;
    assign pulse_cnt   = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_src_seq.sv
// Directed self-checking bench for pulse_src_seq.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pulse_src_seq;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_v1, cfg_v2, cfg_rstep, cfg_fstep;
    logic [CNT_W-1:0] cfg_td, cfg_tw, cfg_tl, cfg_npulse;
    logic             enable;
    logic [WIDTH-1:0] level;
    logic             level_valid;
    logic [2:0]       phase;
    logic             done;
    logic [CNT_W-1:0] pulse_cnt;

    int tests = 0;
    int fails = 0;

    int t2_lvl [10] = '{100, 100, 100, 400, 700, 1000, 1000, 1000, 550, 100};
    int t2_ph  [10] = '{1, 1, 2, 2, 2, 3, 3, 4, 4, 0};

    pulse_src_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_v1      (cfg_v1),
        .cfg_v2      (cfg_v2),
        .cfg_td      (cfg_td),
        .cfg_tw      (cfg_tw),
        .cfg_tl      (cfg_tl),
        .cfg_rstep   (cfg_rstep),
        .cfg_fstep   (cfg_fstep),
        .cfg_npulse  (cfg_npulse),
        .enable      (enable),
        .level       (level),
        .level_valid (level_valid),
        .phase       (phase),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int v1, input int v2, input int td, input int tw, input int tl,
                           input int rs, input int fs, input int np);
        cfg_v1     = WIDTH'(v1);
        cfg_v2     = WIDTH'(v2);
        cfg_td     = CNT_W'(td);
        cfg_tw     = CNT_W'(tw);
        cfg_tl     = CNT_W'(tl);
        cfg_rstep  = WIDTH'(rs);
        cfg_fstep  = WIDTH'(fs);
        cfg_npulse = CNT_W'(np);
    endtask

    initial begin
        int done_at;
        int lows;

        rst_n = 1'b0;
        cfg_valid = 1'b0;
        enable = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", 32'(phase), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(level_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pcnt", 32'(pulse_cnt), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        rst_n = 1'b1;
        tick();

        // Single pulse with handshake and start in the same cycle
        set_cfg(100, 1000, 3, 2, 1, 300, 450, 1);
        cfg_valid = 1'b1;
        enable = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("p1_start_level", 32'(level), 100);
        chk("p1_start_phase", 32'(phase), 1);
        chk("p1_start_valid", 32'(level_valid), 1);
        chk("p1_start_ready", 32'(cfg_ready), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("p1_level_e%0d", i + 1), 32'(level), 32'(t2_lvl[i]));
            chk($sformatf("p1_phase_e%0d", i + 1), 32'(phase), 32'(t2_ph[i]));
        end
        chk("p1_done", 32'(done), 1);
        chk("p1_pcnt", 32'(pulse_cnt), 1);
        chk("p1_valid_end", 32'(level_valid), 0);
        enable = 1'b0;
        tick();
        chk("p1_done_clear", 32'(done), 0);
        chk("p1_idle", 32'(phase), 0);
        chk("p1_hold_v1", 32'(level), 100);

        // Three pulses, 8-cycle period, done on edge 26 after start
        set_cfg(100, 1000, 3, 2, 1, 300, 450, 3);
        cfg_valid = 1'b1;
        enable = 1'b1;
        tick();
        cfg_valid = 1'b0;
        done_at = -1;
        lows = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (phase == 3'd5) lows++;
            if (done) begin
                done_at = n;
                break;
            end
        end
        chk("p3_done_edge", 32'(done_at), 26);
        chk("p3_pcnt", 32'(pulse_cnt), 3);
        chk("p3_low_cycles", 32'(lows), 2);
        enable = 1'b0;
        tick();
        chk("p3_done_once", 32'(done), 0);

        // Upward ramp past the top code must clamp, not wrap
        set_cfg(4000, 4095, 0, 5, 0, 200, 0, 1);
        cfg_valid = 1'b1;
        enable = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("clamp_rise_entry", 32'(level), 4000);
        chk("clamp_rise_phase", 32'(phase), 2);
        tick();
        chk("clamp_level", 32'(level), 4095);
        chk("clamp_phase", 32'(phase), 3);
        enable = 1'b0;
        tick();
        chk("clamp_stop_phase", 32'(phase), 0);
        chk("clamp_stop_level", 32'(level), 4000);
        chk("clamp_stop_valid", 32'(level_valid), 0);

        // Zero step on a downward rise jumps straight to target
        set_cfg(3000, 50, 0, 5, 0, 0, 0, 1);
        cfg_valid = 1'b1;
        enable = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        chk("jump_level", 32'(level), 50);
        chk("jump_phase", 32'(phase), 3);
        enable = 1'b0;
        tick();

        // All-zero timing, infinite: RISE/FALL alternate; cfg changes while running ignored
        set_cfg(10, 20, 0, 0, 0, 0, 0, 0);
        cfg_valid = 1'b1;
        enable = 1'b1;
        tick();
        cfg_v2 = WIDTH'(999);
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (n % 2 == 1) begin
                chk($sformatf("alt_phase_%0d", n), 32'(phase), 2);
                chk($sformatf("alt_level_%0d", n), 32'(level), 10);
                chk($sformatf("alt_pcnt_%0d", n), 32'(pulse_cnt), 32'((n - 1) / 2));
            end else begin
                chk($sformatf("alt_phase_%0d", n), 32'(phase), 4);
                chk($sformatf("alt_level_%0d", n), 32'(level), 20);
                chk($sformatf("alt_pcnt_%0d", n), 32'(pulse_cnt), 32'((n - 2) / 2));
            end
            chk($sformatf("alt_done_%0d", n), 32'(done), 0);
        end
        cfg_valid = 1'b0;
        enable = 1'b0;
        tick();
        chk("alt_stop_ready", 32'(cfg_ready), 1);
        enable = 1'b1;
        tick();
        tick();
        tick();
        chk("alt_cfg_ignored", 32'(level), 20);
        enable = 1'b0;
        tick();

        // Drop enable in HIGH, reconfigure v2, restart
        set_cfg(100, 1000, 0, 4, 0, 0, 0, 1);
        cfg_valid = 1'b1;
        enable = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("stop_in_high", 32'(phase), 3);
        enable = 1'b0;
        tick();
        chk("stop_level", 32'(level), 100);
        chk("stop_valid", 32'(level_valid), 0);
        chk("stop_phase", 32'(phase), 0);
        cfg_v2 = WIDTH'(2000);
        cfg_valid = 1'b1;
        chk("stop_ready", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        tick();
        chk("restart_new_v2", 32'(level), 2000);
        chk("restart_phase", 32'(phase), 3);
        enable = 1'b0;
        tick();

        // Asynchronous reset in the middle of a RISE
        set_cfg(100, 1000, 0, 2, 0, 300, 300, 0);
        cfg_valid = 1'b1;
        enable = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        chk("mid_rise_level", 32'(level), 400);
        chk("mid_rise_phase", 32'(phase), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_phase", 32'(phase), 0);
        chk("arst_ready", 32'(cfg_ready), 1);
        chk("arst_valid", 32'(level_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("nocfg_phase", 32'(phase), 0);
        chk("nocfg_valid", 32'(level_valid), 0);
        chk("nocfg_level", 32'(level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
